// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operation codes
// and the busy/done controller state encoding.
package md_defs;

  localparam int MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

endpackage

// File: rtl/ex_muldiv_md_arith.sv
// Combinational multiply/divide datapath producing the next HI/LO pair from
// latched operands; divide-by-zero and non-arithmetic ops hold HI/LO.
module md_arith
  import md_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [MD_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [WIDTH-1:0]   hi_cur,
  input  logic [WIDTH-1:0]   lo_cur,
  output logic [WIDTH-1:0]   hi_next,
  output logic [WIDTH-1:0]   lo_next
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] prod_s_s;
  logic [2*WIDTH-1:0] prod_u_s;
  logic               div_zero_s;
  logic               is_sdiv_s;
  logic [WIDTH-1:0]   abs_a_s;
  logic [WIDTH-1:0]   abs_b_s;
  logic [WIDTH-1:0]   dvd_s;
  logic [WIDTH-1:0]   dvs_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;

  // Sign-extending to 2*WIDTH makes the truncated product the exact signed result.
  assign prod_s_s = {{WIDTH{op_a[WIDTH-1]}}, op_a} * {{WIDTH{op_b[WIDTH-1]}}, op_b};
  assign prod_u_s = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};

  // One unsigned divider serves both DIV (on magnitudes) and DIVU.
  assign div_zero_s = (op_b == ZERO);
  assign is_sdiv_s  = (op == MD_DIV);
  assign abs_a_s    = op_a[WIDTH-1] ? (ZERO - op_a) : op_a;
  assign abs_b_s    = op_b[WIDTH-1] ? (ZERO - op_b) : op_b;
  assign dvd_s      = is_sdiv_s ? abs_a_s : op_a;
  assign dvs_s      = div_zero_s ? ONE : (is_sdiv_s ? abs_b_s : op_b);
  assign quo_s      = dvd_s / dvs_s;
  assign rem_s      = dvd_s % dvs_s;

  // Result select; signed quotient/remainder get their sign restored here.
  always_comb begin
    hi_next = hi_cur;
    lo_next = lo_cur;
    case (op)
      MD_MULT:  {hi_next, lo_next} = prod_s_s;
      MD_MULTU: {hi_next, lo_next} = prod_u_s;
      MD_DIV: begin
        if (div_zero_s) begin
          hi_next = hi_cur;
          lo_next = lo_cur;
        end else begin
          lo_next = (op_a[WIDTH-1] ^ op_b[WIDTH-1]) ? (ZERO - quo_s) : quo_s;
          hi_next = op_a[WIDTH-1] ? (ZERO - rem_s) : rem_s;
        end
      end
      MD_DIVU: begin
        if (div_zero_s) begin
          hi_next = hi_cur;
          lo_next = lo_cur;
        end else begin
          lo_next = quo_s;
          hi_next = rem_s;
        end
      end
      default: begin
        hi_next = hi_cur;
        lo_next = lo_cur;
      end
    endcase
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle multiply/divide unit: latches operands on start, holds
// busy for a fixed latency, then commits the result to the HI/LO registers.
module ex_muldiv
  import md_defs::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [WIDTH-1:0]   srca,
  input  logic [WIDTH-1:0]   srcb,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               done
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  md_state_t          state_r, state_n;
  logic [CNT_W-1:0]   count_r, count_n;
  logic [WIDTH-1:0]   a_r, a_n;
  logic [WIDTH-1:0]   b_r, b_n;
  logic [MD_OP_W-1:0] op_r, op_n;
  logic [WIDTH-1:0]   hi_r, hi_n;
  logic [WIDTH-1:0]   lo_r, lo_n;
  logic               busy_r, busy_n;
  logic               done_r, done_n;
  logic [WIDTH-1:0]   arith_hi_s;
  logic [WIDTH-1:0]   arith_lo_s;

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .op      (op_r),
    .op_a    (a_r),
    .op_b    (b_r),
    .hi_cur  (hi_r),
    .lo_cur  (lo_r),
    .hi_next (arith_hi_s),
    .lo_next (arith_lo_s)
  );

  // Next-state logic: capture in IDLE, count down and commit in RUN.
  always_comb begin
    state_n = state_r;
    count_n = count_r;
    a_n     = a_r;
    b_n     = b_r;
    op_n    = op_r;
    hi_n    = hi_r;
    lo_n    = lo_r;
    busy_n  = busy_r;
    done_n  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              a_n     = srca;
              b_n     = srcb;
              op_n    = md_op;
              count_n = ((md_op == MD_MULT) || (md_op == MD_MULTU)) ? CNT_MULT : CNT_DIV;
              state_n = ST_RUN;
              busy_n  = 1'b1;
            end
            MD_MTHI: hi_n = srca;
            MD_MTLO: lo_n = srca;
            default: state_n = ST_IDLE;
          endcase
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Requests arriving while busy are dropped; the hazard unit stalls them.
        if (count_r == CNT_ONE) begin
          hi_n    = arith_hi_s;
          lo_n    = arith_lo_s;
          count_n = {CNT_W{1'b0}};
          state_n = ST_IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          count_n = count_r - CNT_ONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        count_n = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and HI/LO registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      count_r <= {CNT_W{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      op_r    <= MD_NONE;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      count_r <= count_n;
      a_r     <= a_n;
      b_r     <= b_n;
      op_r    <= op_n;
      hi_r    <= hi_n;
      lo_r    <= lo_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized scoreboard bench for ex_muldiv against a plain-arithmetic model,
// plus directed corner cases and a MULT_CYCLES=1 instance.
module tb_ex_muldiv;
  import md_defs::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, busy, done;
  logic [2:0]  md_op;
  logic [31:0] srca, srcb, hi, lo;

  logic        start1, busy1, done1;
  logic [2:0]  md_op1;
  logic [31:0] srca1, srcb1, hi1, lo1;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) u_dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .srca(srca),
    .srcb(srcb), .busy(busy), .hi(hi), .lo(lo), .done(done));

  ex_muldiv #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .md_op(md_op1), .srca(srca1),
    .srcb(srcb1), .busy(busy1), .hi(hi1), .lo(lo1), .done(done1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: updates architectural HI/LO and queues mult/div results.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      MD_MULT: begin
        p = 64'(sa * sb);
        {m_hi, m_lo} = p;
        exp_q.push_back(p);
      end
      MD_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        {m_hi, m_lo} = p;
        exp_q.push_back(p);
      end
      MD_DIV: begin
        if (b != 32'd0) begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
        exp_q.push_back({m_hi, m_lo});
      end
      MD_DIVU: begin
        if (b != 32'd0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
        exp_q.push_back({m_hi, m_lo});
      end
      MD_MTHI: m_hi = a;
      MD_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue one request; returns at #1 into the first cycle after completion.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n, want;
    @(posedge clk); #1;
    start = 1'b1; md_op = op; srca = a; srcb = b;
    model(op, a, b);
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE; srca = $urandom; srcb = $urandom;
    if (op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU) begin
      want = (op == MD_MULT || op == MD_MULTU) ? MC : DC;
      n = 0;
      while (busy && n < 100) begin
        n++;
        @(posedge clk); #1;
      end
      chk("busy_cycles", 64'(n), 64'(want));
    end else begin
      chk("no_busy", {63'd0, busy}, 64'd0);
    end
    chk("hilo_model", {hi, lo}, {m_hi, m_lo});
  endtask

  // Monitor: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        chk("done_result", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          dn;
    reset = 1'b1; start = 1'b0; md_op = MD_NONE; srca = 32'd0; srcb = 32'd0;
    start1 = 1'b0; md_op1 = MD_NONE; srca1 = 32'd0; srcb1 = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);

    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(MD_DIVU, 32'd7, 32'd2);
    chk("divu", {hi, lo}, 64'h0000_0001_0000_0003);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_min", {hi, lo}, 64'h0000_0000_8000_0000);
    issue(MD_MTHI, 32'h11, 32'd0);
    issue(MD_MTLO, 32'h22, 32'd0);
    issue(MD_DIVU, 32'd1234, 32'd0);
    chk("divu_zero", {hi, lo}, 64'h0000_0011_0000_0022);
    issue(MD_MTLO, 32'hABCD, 32'd0);
    chk("mtlo", {32'd0, lo}, 64'h0000_ABCD);
    issue(3'd7, 32'h5A5A, 32'h1);
    issue(MD_NONE, 32'h5A5A, 32'h1);

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(op, a, b);
    end

    // MULTU at T, ignored MTHI at T+2, reset at T+3.
    @(posedge clk); #1;
    start = 1'b1; md_op = MD_MULTU; srca = 32'hFFFF; srcb = 32'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; md_op = MD_MTHI; srca = 32'h55;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_NONE;
    chk("mthi_ignored", {32'd0, hi}, {32'd0, m_hi});
    chk("busy_mid", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    dn = 0;
    repeat (12) begin
      dn += int'(done);
      @(posedge clk); #1;
    end
    chk("abort_no_done", 64'(dn), 64'd0);

    // Single-cycle multiply instance.
    start1 = 1'b1; md_op1 = MD_MULTU; srca1 = 32'hFFFF_FFFF; srcb1 = 32'd2;
    @(posedge clk); #1;
    start1 = 1'b0; md_op1 = MD_NONE;
    chk("mc1_busy_t1", {62'd0, busy1, done1}, 64'd2);
    @(posedge clk); #1;
    chk("mc1_busy_t2", {62'd0, busy1, done1}, 64'd1);
    chk("mc1_result", {hi1, lo1}, 64'h0000_0001_FFFF_FFFE);
    @(posedge clk); #1;
    chk("mc1_done_once", {63'd0, done1}, 64'd0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
